alu_muldiv_sequencer: RTL

Multi-cycle controller that performs 64-bit unsigned multiply (128-bit product) and unsigned divide (quotient and remainder) using the existing ALU. It issues one ALU operation per cycle, 64 steps per instruction. It sits beside the execute stage and owns the ALU operand and function-select inputs while busy. Shift and bit-shuffle work happens in its own working registers. The ALU performs only the add and subtract.

---
 rtl/alu_muldiv_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_muldiv_sequencer: 64-step shift-add multiply / restoring divide      |
// | driving an external add/subtract ALU.                Revision: 1.0       |
// +--------------------------------------------------------------------------+
module alu_muldiv_sequencer #(
  parameter int N = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fs,
  input  logic [N-1:0] alu_f,
  input  logic [3:0]   alu_status,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [N-1:0] result_hi,
  output logic [N-1:0] result_lo
);

  localparam logic [5:0] CNT_LAST = 6'(N - 1);
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic       OP_MUL   = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] hi, hi_next;
  logic [N-1:0] lo, lo_next;
  logic [N-1:0] m, m_next;
  logic         opreg, opreg_next;
  logic [5:0]   cnt, cnt_next;
  logic         done_r, done_next;
  logic         dz_r, dz_next;

  logic [N-1:0] rs;
  logic         carry;
  logic         take;
  logic         unused_flags;

  // Only the carry flag matters: it is the 65th sum bit for MUL and the
  // not-borrow indication for DIV.
  assign carry        = alu_status[2];
  assign unused_flags = ^{alu_status[3], alu_status[1:0]};
  assign rs           = {hi[N-2:0], lo[N-1]};
  assign take         = hi[N-1] | carry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      opreg  <= 1'b0;
      cnt    <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      state  <= state_next;
      hi     <= hi_next;
      lo     <= lo_next;
      m      <= m_next;
      opreg  <= opreg_next;
      cnt    <= cnt_next;
      done_r <= done_next;
      dz_r   <= dz_next;
    end
  end

  always_comb begin
    state_next = state;
    hi_next    = hi;
    lo_next    = lo;
    m_next     = m;
    opreg_next = opreg;
    cnt_next   = cnt;
    done_next  = 1'b0;
    dz_next    = dz_r;
    alu_a      = '0;
    alu_b      = '0;
    alu_fs     = 5'b00000;

    case (state)
      IDLE: begin
        if (start) begin
          opreg_next = op;
          hi_next    = '0;
          cnt_next   = CNT_LAST;
          dz_next    = 1'b0;
          if (op == OP_MUL) begin
            lo_next    = opb;
            m_next     = opa;
            state_next = STEP;
          end else if (opb != '0) begin
            lo_next    = opa;
            m_next     = opb;
            state_next = STEP;
          end else begin
            // Divide by zero completes without stepping: remainder is the
            // dividend, quotient saturates to all ones.
            hi_next   = opa;
            lo_next   = '1;
            dz_next   = 1'b1;
            done_next = 1'b1;
          end
        end
      end

      STEP: begin
        if (opreg == OP_MUL) begin
          alu_a   = hi;
          alu_b   = lo[0] ? m : '0;
          alu_fs  = FS_ADD;
          hi_next = {carry, alu_f[N-1:1]};
          lo_next = {alu_f[0], lo[N-1:1]};
        end else begin
          alu_a   = rs;
          alu_b   = m;
          alu_fs  = FS_SUB;
          hi_next = take ? alu_f : rs;
          lo_next = {lo[N-2:0], take};
        end
        cnt_next = cnt - 6'd1;
        if (cnt == 6'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == STEP);
  assign done      = done_r;
  assign dz        = dz_r;
  assign result_hi = hi;
  assign result_lo = lo;

endmodule
`default_nettype wire
